mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle sequencer for the MIPS datapath: one shared ALU, one unified instruction/data memory, and IR, A/B and ALUOut holding registers.
- Moore FSM, decoded from opcode/funct held in IR. Each state drives the datapath selects, write enables and the 4-bit ALU code.
- Same ALU encoding as the single-cycle control: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1110.
- Supports add, sub, and, or, slt, sll, jr, lw, sw, beq, bne, j, jal, addi, ori.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- RA_REG, 31, destination register index used by jal (informational; datapath hardwires rd mux input 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (current cycle).
- mem_ready  in  1  memory access complete (present only with MEM_READY_EN).
- pc_we  out  1  PC write.
- ir_we  out  1  IR load.
- iord  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write.
- reg_dst  out  2  write register: 0=rt, 1=rd, 2=r31.
- mem_to_reg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC (already PC+4).
- alu_src_a  out  1  0=PC, 1=A.
- alu_src_b  out  2  0=B, 1=const 4, 2=ext imm, 3=ext imm<<2.
- zero_ext  out  1  1 = zero-extend imm16 (ori), 0 = sign-extend.
- alu_control  out  4  ALU operation code.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],IR[25:0],2'b00}, 3=A (jr).
- illegal_op  out  1  one-cycle pulse on unsupported opcode/funct.
- instr_done  out  1  one-cycle pulse in final state of each instruction.
- instr_count  out  CNT_W  retired instructions, wraps.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: when rst_n is low at a clk edge, state goes to FETCH and instr_count to 0. While rst_n is low, all write/strobe outputs (pc_we, ir_we, mem_read, mem_write, reg_write) are forced 0, illegal_op and instr_done are 0, and all select outputs are 0. Reset mid-instruction abandons that instruction with no partial writes.
- Outputs are combinational from state (plus opcode/funct/zero where noted). Unlisted outputs are 0.
- FETCH: mem_read, ir_we, pc_we; src_a=0, src_b=1, ADD, pc_src=0. Next state DECODE.
- DECODE: src_a=0, src_b=3, sign-extend, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R-type with funct add/sub/and/or/slt/sll -> R_EXEC
  - funct 8 -> JR
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - addi/ori -> I_EXEC
  - anything else -> FETCH with illegal_op=1 and no instr_done.
- MEM_ADDR: src_a=1, src_b=2, ADD. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: iord=1, mem_read. Next state MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1, instr_done. Next state FETCH.
- MEM_WR: iord=1, mem_write, instr_done. Next state FETCH.
- R_EXEC: src_a=1, src_b=0, alu_control from funct. Next state R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0, instr_done. Next state FETCH.
- I_EXEC: src_a=1, src_b=2, ADD (addi) or OR with zero_ext=1 (ori). Next state I_WB.
- I_WB: reg_write, reg_dst=0, zero_ext held, instr_done. Next state FETCH.
- BRANCH: src_a=1, src_b=0, SUB, pc_src=1, instr_done. pc_we = (beq & zero) | (bne & ~zero). Next state FETCH.
- JUMP: pc_we, pc_src=2, instr_done. Next state FETCH.
- JAL: pc_we, pc_src=2, reg_write, reg_dst=2, mem_to_reg=2, instr_done. Next state FETCH.
- JR: pc_we, pc_src=3, instr_done. Next state FETCH.
- Cycle counts: branch/j/jal/jr 3; R-type/addi/ori/sw 4; lw 5.
- instr_count increments on every instr_done cycle and wraps from all-ones to 0.
- State encoding (4 bits): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12, JR 13. Codes 14–15 go to FETCH.

Optional Feature:
- Macro MIPS_CTRL_MEM_READY_EN.
- Defined: the mem_ready port exists. FETCH, MEM_RD and MEM_WR hold state until mem_ready=1, with strobes asserted every cycle. ir_we, pc_we (FETCH) and instr_done (MEM_WR) are asserted only in the mem_ready=1 cycle.
- Undefined: the port is absent and every memory access takes one cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state localparams
  - opcode constants (R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000, ori 001101)
  - funct constants (add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000)
  - ALU codes
  - mux select encodings
- Sub-module mips_alu_decode: combinational mapping from funct to alu_control plus an R-type legality flag. Shared by R_EXEC and DECODE.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-MEM_RD -> state_o=0, all enables 0, instr_count=0; release -> FETCH asserts mem_read, ir_we, pc_we.
- lw (opcode 100011) -> states 0,1,2,3,4; MEM_WB has reg_write=1, mem_to_reg=1, reg_dst=0; instr_count +1 after 5 cycles.
- beq with zero=1 -> pc_we=1, pc_src=1 in BRANCH. bne with zero=1 -> pc_we=0. Both complete in 3 cycles.
- jal (000011) -> JAL asserts pc_we, reg_write, reg_dst=2, mem_to_reg=2. jr (funct 8) -> pc_src=3.
- opcode 111111 -> DECODE pulses illegal_op=1, returns to FETCH, instr_count unchanged.
- With MIPS_CTRL_MEM_READY_EN: sw with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, instr_done only in the mem_ready cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Purpose: shared constants and the control-word type for the multicycle MIPS sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // FSM state codes (4-bit, stable encoding seen on state_o)
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JAL      = 4'd12;
    localparam logic [3:0] S_JR       = 4'd13;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1110;

    // Datapath mux select encodings
    localparam logic [1:0] REGDST_RT    = 2'd0;
    localparam logic [1:0] REGDST_RD    = 2'd1;
    localparam logic [1:0] REGDST_RA    = 2'd2;
    localparam logic [1:0] MTR_ALUOUT   = 2'd0;
    localparam logic [1:0] MTR_MDR      = 2'd1;
    localparam logic [1:0] MTR_PC       = 2'd2;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_A       = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    // Everything the FSM drives per state, bundled so the reset gate is one assignment
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose: controller <-> datapath bundle; master = controller, slave = datapath.
// Latency: n/a (wires only).
// Backpressure: mem_ready exists only when MIPS_CTRL_MEM_READY_EN is defined.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
`ifdef MIPS_CTRL_MEM_READY_EN
    logic             mem_ready;
`endif
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_we;
    logic             ir_we;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             zero_ext;
    logic [3:0]       alu_control;
    logic [1:0]       pc_src;
    logic             illegal_op;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_o;

    modport master (
`ifdef MIPS_CTRL_MEM_READY_EN
        input  mem_ready,
`endif
        input  opcode, funct, zero,
        output pc_we, ir_we, iord, mem_read, mem_write, reg_write,
        output reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext,
        output alu_control, pc_src, illegal_op, instr_done,
        output instr_count, state_o
    );

    modport slave (
`ifdef MIPS_CTRL_MEM_READY_EN
        output mem_ready,
`endif
        output opcode, funct, zero,
        input  pc_we, ir_we, iord, mem_read, mem_write, reg_write,
        input  reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext,
        input  alu_control, pc_src, illegal_op, instr_done,
        input  instr_count, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Purpose: funct -> ALU code plus legality flag for the arithmetic R-type ops (jr excluded).
// Latency: combinational.
// Backpressure: none.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       r_legal
);
    always_comb begin
        alu_control = ALU_ADD;
        r_legal     = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_SLL:  alu_control = ALU_SLL;
            default: r_legal     = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose: Moore sequencer for the multicycle MIPS datapath (ports: clk, rst_n, ctl master bundle).
// Latency: 3 cycles branch/j/jal/jr, 4 R-type/addi/ori/sw, 5 lw; retired count visible the cycle after instr_done.
// Backpressure: with MIPS_CTRL_MEM_READY_EN, FETCH/MEM_RD/MEM_WR hold until mem_ready; otherwise none.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int RA_REG = 31
)(
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master ctl
);
    // The datapath hardwires r31 on reg_dst input 2; any other link register is unsupported.
    if (RA_REG != 31) begin : g_ra_chk
        $error("mips_multicycle_ctrl: RA_REG must be 31");
    end

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       r_alu;
    logic             r_legal;
    logic             mem_rdy;
    ctrl_t            c;
    ctrl_t            c_out;

`ifdef MIPS_CTRL_MEM_READY_EN
    assign mem_rdy = ctl.mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    mips_alu_decode u_alu_dec (
        .funct       (ctl.funct),
        .alu_control (r_alu),
        .r_legal     (r_legal)
    );

    always_comb begin
        c         = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                c.mem_read    = 1'b1;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
                c.pc_src      = PCSRC_ALU;
                // IR/PC only commit once the memory word is actually there
                c.ir_we       = mem_rdy;
                c.pc_we       = mem_rdy;
                if (mem_rdy) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                c.alu_src_a   = SRCA_PC;
                c.alu_src_b   = SRCB_IMM_SH2;
                c.alu_control = ALU_ADD;
                state_nxt     = S_FETCH;
                case (ctl.opcode)
                    OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (ctl.funct == FN_JR) state_nxt = S_JR;
                        else if (r_legal)       state_nxt = S_R_EXEC;
                        else                    c.illegal_op = 1'b1;
                    end
                    OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
                    OP_J:            state_nxt = S_JUMP;
                    OP_JAL:          state_nxt = S_JAL;
                    OP_ADDI, OP_ORI: state_nxt = S_I_EXEC;
                    default:         c.illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                c.alu_src_a   = SRCA_A;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
                state_nxt     = (ctl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                if (mem_rdy) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = MTR_MDR;
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEM_WR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = mem_rdy;
                if (mem_rdy) state_nxt = S_FETCH;
            end
            S_R_EXEC: begin
                c.alu_src_a   = SRCA_A;
                c.alu_src_b   = SRCB_B;
                c.alu_control = r_alu;
                state_nxt     = S_R_WB;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RD;
                c.mem_to_reg = MTR_ALUOUT;
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_I_EXEC: begin
                c.alu_src_a   = SRCA_A;
                c.alu_src_b   = SRCB_IMM;
                c.zero_ext    = (ctl.opcode == OP_ORI);
                c.alu_control = (ctl.opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                state_nxt     = S_I_WB;
            end
            S_I_WB: begin
                // zero_ext stays up so the datapath sees a stable immediate during writeback
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = MTR_ALUOUT;
                c.zero_ext   = (ctl.opcode == OP_ORI);
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a   = SRCA_A;
                c.alu_src_b   = SRCB_B;
                c.alu_control = ALU_SUB;
                c.pc_src      = PCSRC_ALUOUT;
                c.pc_we       = ((ctl.opcode == OP_BEQ) &&  ctl.zero) ||
                                ((ctl.opcode == OP_BNE) && !ctl.zero);
                c.instr_done  = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_JUMP: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PCSRC_JUMP;
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JAL: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PCSRC_JUMP;
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RA;
                c.mem_to_reg = MTR_PC;
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JR: begin
                c.pc_we      = 1'b1;
                c.pc_src     = PCSRC_REG;
                c.instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset is sampled on the edge but must also silence the datapath immediately,
    // so a reset landing mid-instruction never leaves a partial write behind.
    assign c_out = rst_n ? c : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (c.instr_done) cnt <= cnt + 1'b1;
        end
    end

    assign ctl.pc_we       = c_out.pc_we;
    assign ctl.ir_we       = c_out.ir_we;
    assign ctl.iord        = c_out.iord;
    assign ctl.mem_read    = c_out.mem_read;
    assign ctl.mem_write   = c_out.mem_write;
    assign ctl.reg_write   = c_out.reg_write;
    assign ctl.reg_dst     = c_out.reg_dst;
    assign ctl.mem_to_reg  = c_out.mem_to_reg;
    assign ctl.alu_src_a   = c_out.alu_src_a;
    assign ctl.alu_src_b   = c_out.alu_src_b;
    assign ctl.zero_ext    = c_out.zero_ext;
    assign ctl.alu_control = c_out.alu_control;
    assign ctl.pc_src      = c_out.pc_src;
    assign ctl.illegal_op  = c_out.illegal_op;
    assign ctl.instr_done  = c_out.instr_done;
    assign ctl.instr_count = cnt;
    assign ctl.state_o     = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: scoreboard bench for mips_multicycle_ctrl; per-cycle expected control words queued per instruction.
// Latency: checks every cycle of every instruction, sampled 1ns after the falling edge.
// Backpressure: mem_ready stall sequence exercised only when MIPS_CTRL_MEM_READY_EN is defined.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(32)) ifc ();

    mips_multicycle_ctrl #(.CNT_W(32), .RA_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ifc)
    );

    typedef struct {
        logic [3:0]  st;
        logic [21:0] ctl;
        logic [31:0] cnt;
        logic        rdy;
    } rec_t;

    rec_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {pc_we,ir_we,iord,mem_read,mem_write,reg_write,reg_dst,mem_to_reg,src_a,src_b,zero_ext,alu,pc_src,illegal,done}
    function automatic logic [21:0] mk(
        input logic pw, input logic iw, input logic io, input logic mr, input logic mw,
        input logic rw, input logic [1:0] rd, input logic [1:0] mtr, input logic sa,
        input logic [1:0] sb, input logic ze, input logic [3:0] alu, input logic [1:0] ps,
        input logic ill, input logic dn);
        return {pw, iw, io, mr, mw, rw, rd, mtr, sa, sb, ze, alu, ps, ill, dn};
    endfunction

    function automatic logic [21:0] obs();
        return {ifc.pc_we, ifc.ir_we, ifc.iord, ifc.mem_read, ifc.mem_write, ifc.reg_write,
                ifc.reg_dst, ifc.mem_to_reg, ifc.alu_src_a, ifc.alu_src_b, ifc.zero_ext,
                ifc.alu_control, ifc.pc_src, ifc.illegal_op, ifc.instr_done};
    endfunction

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_OR  = 4'b0001;

    function automatic logic [21:0] fetch_w();
        return mk(1,1,0,1,0,0,2'd0,2'd0,0,2'd1,0,A_ADD,2'd0,0,0);
    endfunction

    function automatic logic [21:0] dec_w(input logic ill);
        return mk(0,0,0,0,0,0,2'd0,2'd0,0,2'd3,0,A_ADD,2'd0,ill,0);
    endfunction

    task automatic push(input logic [3:0] st, input logic [21:0] w, input logic rdy);
        rec_t r;
        r.st  = st;
        r.ctl = w;
        r.cnt = exp_cnt;
        r.rdy = rdy;
        if (w[0]) exp_cnt++;
        sbq.push_back(r);
    endtask

    // Pops and checks one record per cycle; entered with the DUT sitting in FETCH.
    task automatic drain(input string name, input bit adv_last);
        int n;
        rec_t r;
        n = sbq.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            r = sbq.pop_front();
`ifdef MIPS_CTRL_MEM_READY_EN
            ifc.mem_ready = r.rdy;
`endif
            #1;
            chk($sformatf("%s c%0d state", name, i), 32'(ifc.state_o), 32'(r.st));
            chk($sformatf("%s c%0d ctl", name, i), 32'(obs()), 32'(r.ctl));
            chk($sformatf("%s c%0d cnt", name, i), ifc.instr_count, r.cnt);
        end
        if (adv_last) @(negedge clk);
    endtask

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1110;
        endcase
    endfunction

    task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic taken;
        ifc.opcode = op;
        ifc.funct  = fn;
        ifc.zero   = z;
        push(4'd0, fetch_w(), 1'b1);
        case (op)
            6'b100011: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd2, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,A_ADD,2'd0,0,0), 1'b1);
                push(4'd3, mk(0,0,1,1,0,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,0), 1'b1);
                push(4'd4, mk(0,0,0,0,0,1,2'd0,2'd1,0,2'd0,0,4'd0,2'd0,0,1), 1'b1);
            end
            6'b101011: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd2, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,A_ADD,2'd0,0,0), 1'b1);
                push(4'd5, mk(0,0,1,0,1,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,1), 1'b1);
            end
            6'b000000: begin
                if (fn == 6'b001000) begin
                    push(4'd1, dec_w(0), 1'b1);
                    push(4'd13, mk(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd3,0,1), 1'b1);
                end else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000}) begin
                    push(4'd1, dec_w(0), 1'b1);
                    push(4'd6, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,0,r_alu(fn),2'd0,0,0), 1'b1);
                    push(4'd7, mk(0,0,0,0,0,1,2'd1,2'd0,0,2'd0,0,4'd0,2'd0,0,1), 1'b1);
                end else begin
                    push(4'd1, dec_w(1), 1'b1);
                end
            end
            6'b000100, 6'b000101: begin
                taken = (op == 6'b000100) ? z : !z;
                push(4'd1, dec_w(0), 1'b1);
                push(4'd10, mk(taken,0,0,0,0,0,2'd0,2'd0,1,2'd0,0,A_SUB,2'd1,0,1), 1'b1);
            end
            6'b000010: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd11, mk(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd2,0,1), 1'b1);
            end
            6'b000011: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd12, mk(1,0,0,0,0,1,2'd2,2'd2,0,2'd0,0,4'd0,2'd2,0,1), 1'b1);
            end
            6'b001000: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd8, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,A_ADD,2'd0,0,0), 1'b1);
                push(4'd9, mk(0,0,0,0,0,1,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,1), 1'b1);
            end
            6'b001101: begin
                push(4'd1, dec_w(0), 1'b1);
                push(4'd8, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,1,A_OR,2'd0,0,0), 1'b1);
                push(4'd9, mk(0,0,0,0,0,1,2'd0,2'd0,0,2'd0,1,4'd0,2'd0,0,1), 1'b1);
            end
            default: push(4'd1, dec_w(1), 1'b1);
        endcase
        drain(name, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        ifc.opcode = 6'd0;
        ifc.funct  = 6'd0;
        ifc.zero   = 1'b0;
`ifdef MIPS_CTRL_MEM_READY_EN
        ifc.mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("por state", 32'(ifc.state_o), 32'd0);
        chk("por ctl", 32'(obs()), 32'd0);
        chk("por cnt", ifc.instr_count, 32'd0);
        rst_n = 1'b1;

        issue("lw",    6'b100011, 6'd0,      1'b0);
        issue("sw",    6'b101011, 6'd0,      1'b0);
        issue("add",   6'b000000, 6'b100000, 1'b0);
        issue("sub",   6'b000000, 6'b100010, 1'b0);
        issue("and",   6'b000000, 6'b100100, 1'b0);
        issue("or",    6'b000000, 6'b100101, 1'b0);
        issue("slt",   6'b000000, 6'b101010, 1'b0);
        issue("sll",   6'b000000, 6'b000000, 1'b0);
        issue("addi",  6'b001000, 6'b010101, 1'b0);
        issue("ori",   6'b001101, 6'b010101, 1'b0);
        issue("beq1",  6'b000100, 6'd0,      1'b1);
        issue("beq0",  6'b000100, 6'd0,      1'b0);
        issue("bne1",  6'b000101, 6'd0,      1'b1);
        issue("bne0",  6'b000101, 6'd0,      1'b0);
        issue("j",     6'b000010, 6'd0,      1'b0);
        issue("jal",   6'b000011, 6'd0,      1'b0);
        issue("jr",    6'b000000, 6'b001000, 1'b0);
        issue("ill_op", 6'b111111, 6'd0,     1'b0);
        issue("ill_fn", 6'b000000, 6'b000001, 1'b0);

        // Reset landing in MEM_RD of a load
        ifc.opcode = 6'b100011;
        push(4'd0, fetch_w(), 1'b1);
        push(4'd1, dec_w(0), 1'b1);
        push(4'd2, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,A_ADD,2'd0,0,0), 1'b1);
        push(4'd3, mk(0,0,1,1,0,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,0), 1'b1);
        drain("lw_rst", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst gate ctl", 32'(obs()), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rst c%0d state", k), 32'(ifc.state_o), 32'd0);
            chk($sformatf("rst c%0d ctl", k), 32'(obs()), 32'd0);
            chk($sformatf("rst c%0d cnt", k), ifc.instr_count, 32'd0);
        end
        rst_n   = 1'b1;
        exp_cnt = 0;
        #1;
        chk("rel fetch ctl", 32'(obs()), 32'(fetch_w()));

        issue("lw2",  6'b100011, 6'd0, 1'b0);
        issue("ori2", 6'b001101, 6'd0, 1'b0);

`ifdef MIPS_CTRL_MEM_READY_EN
        // Store with one fetch stall and three write stalls
        ifc.opcode = 6'b101011;
        push(4'd0, mk(0,0,0,1,0,0,2'd0,2'd0,0,2'd1,0,A_ADD,2'd0,0,0), 1'b0);
        push(4'd0, fetch_w(), 1'b1);
        push(4'd1, dec_w(0), 1'b1);
        push(4'd2, mk(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,A_ADD,2'd0,0,0), 1'b1);
        for (int k = 0; k < 3; k++)
            push(4'd5, mk(0,0,1,0,1,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,0), 1'b0);
        push(4'd5, mk(0,0,1,0,1,0,2'd0,2'd0,0,2'd0,0,4'd0,2'd0,0,1), 1'b1);
        drain("sw_rdy", 1'b1);
`endif

        #1;
        chk("end state", 32'(ifc.state_o), 32'd0);
        chk("end cnt", ifc.instr_count, exp_cnt);
        chk("end queue", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
